// File: rtl/fs_rx_byte_fifo_if.sv
// ---------------------------------------------------------------------------
// fs_rx_byte_fifo_if
// Bundles the receiver-side byte strobe, the bus-side valid/ready stream and
// the status/overflow signals of fs_rx_byte_fifo.
//
// Signals:
//   i_data / i_valid      byte strobe from the fast-serial receiver
//   o_data / o_valid      head byte of the first-word-fall-through stream
//   i_ready               consumer accepts o_data when o_valid=1
//   o_level               bytes held, output register included
//   o_full / o_empty      decodes of o_level
//   o_overflow            sticky drop flag
//   i_clr_overflow        synchronous clear of o_overflow (and drop counter)
//   o_drop_count          saturating drop counter (FS_RX_FIFO_DROP_CNT_EN only)
//
// Modports: slave = the FIFO, master = the logic driving/consuming it.
// Optional feature macro: FS_RX_FIFO_DROP_CNT_EN
// ---------------------------------------------------------------------------
interface fs_rx_byte_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic [DATA_W-1:0]   i_data;
    logic                i_valid;
    logic [DATA_W-1:0]   o_data;
    logic                o_valid;
    logic                i_ready;
    logic [DEPTH_LOG2:0] o_level;
    logic                o_full;
    logic                o_empty;
    logic                o_overflow;
    logic                i_clr_overflow;
`ifdef FS_RX_FIFO_DROP_CNT_EN
    logic [15:0]         o_drop_count;

    modport slave (
        input  i_data, i_valid, i_ready, i_clr_overflow,
        output o_data, o_valid, o_level, o_full, o_empty, o_overflow, o_drop_count
    );
    modport master (
        output i_data, i_valid, i_ready, i_clr_overflow,
        input  o_data, o_valid, o_level, o_full, o_empty, o_overflow, o_drop_count
    );
`else
    modport slave (
        input  i_data, i_valid, i_ready, i_clr_overflow,
        output o_data, o_valid, o_level, o_full, o_empty, o_overflow
    );
    modport master (
        output i_data, i_valid, i_ready, i_clr_overflow,
        input  o_data, o_valid, o_level, o_full, o_empty, o_overflow
    );
`endif
endinterface

// File: rtl/fs_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// fs_rx_byte_fifo
// Elastic byte buffer between the fast-serial receiver (un-stallable
// single-cycle strobes) and an Avalon-ST style valid/ready consumer.
// Storage is a (DEPTH-1)-entry circular RAM plus a registered output stage
// that gives first-word-fall-through behaviour; total capacity is DEPTH.
// Bytes arriving while full with no pop are dropped and flag o_overflow.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      fs_rx_byte_fifo_if.slave (data in/out, handshake, status)
//
// Optional feature macro: FS_RX_FIFO_DROP_CNT_EN adds bus.o_drop_count, a
// 16-bit saturating count of dropped bytes cleared by i_clr_overflow.
// ---------------------------------------------------------------------------
module fs_rx_byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    fs_rx_byte_fifo_if.slave bus
);
    localparam int RAM_N = (2 ** DEPTH_LOG2) - 1;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(2 ** DEPTH_LOG2);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = DEPTH_LOG2'(RAM_N - 1);

    // Pointers wrap modulo DEPTH-1, not modulo 2**DEPTH_LOG2.
    function automatic logic [DEPTH_LOG2-1:0] next_ptr(input logic [DEPTH_LOG2-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_W-1:0]     ram_q [RAM_N];

    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;

    logic                  pop, push, drop, bypass, ram_we, ram_empty;
    logic [DEPTH_LOG2:0]   ram_cnt;

    // RAM occupancy is everything held except the output register.
    assign ram_cnt   = level_q - {{DEPTH_LOG2{1'b0}}, out_valid_q};
    assign ram_empty = (ram_cnt == '0);

    assign pop    = out_valid_q && bus.i_ready;
    assign push   = bus.i_valid && ((level_q < LVL_FULL) || pop);
    assign drop   = bus.i_valid && !push;
    // Output register is free after this cycle: either it was empty, or it
    // is being popped with nothing in RAM to refill it.
    assign bypass = push && (!out_valid_q || (pop && ram_empty));
    assign ram_we = push && !bypass;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        if (pop && !ram_empty) begin
            out_data_d  = ram_q[rd_ptr_q];
            out_valid_d = 1'b1;
            rd_ptr_d    = next_ptr(rd_ptr_q);
        end else if (bypass) begin
            out_data_d  = bus.i_data;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        if (ram_we) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end

        level_d = level_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};

        // Set beats clear when both happen in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.i_clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            ram_q[wr_ptr_q] <= bus.i_data;
        end
    end

    assign bus.o_data     = out_data_q;
    assign bus.o_valid    = out_valid_q;
    assign bus.o_level    = level_q;
    assign bus.o_full     = (level_q == LVL_FULL);
    assign bus.o_empty    = (level_q == '0);
    assign bus.o_overflow = ovf_q;

`ifdef FS_RX_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A clear and a drop in the same cycle restart the count at one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.i_clr_overflow) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.o_drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_fs_rx_byte_fifo.sv
module tb_fs_rx_byte_fifo;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fs_rx_byte_fifo_if #(.DATA_W(8), .DEPTH_LOG2(4)) bus ();

    fs_rx_byte_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_valid        = 1'b0;
        bus.i_data         = 8'h00;
        bus.i_ready        = 1'b0;
        bus.i_clr_overflow = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Push values base..base+n-1 with i_ready low.
    task automatic fill(input logic [7:0] base, input int n);
        bus.i_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = base + 8'(i);
            tick();
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #5;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_level !== 5'd0 || bus.o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b level=%0d data=%h, need 0/0/00",
                     bus.o_valid, bus.o_level, bus.o_data);
        end
        checks++;
        if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: empty=%b full=%b ovf=%b, need 1/0/0",
                     bus.o_empty, bus.o_full, bus.o_overflow);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hA5;
        tick();
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hA5 || bus.o_level !== 5'd1) begin
            errors++;
            $display("FAIL single_latency: valid=%b data=%h level=%0d, need 1/a5/1",
                     bus.o_valid, bus.o_data, bus.o_level);
        end
        tick();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_level !== 5'd0 || bus.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: valid=%b level=%0d empty=%b, need 0/0/1",
                     bus.o_valid, bus.o_level, bus.o_empty);
        end
        bus.i_ready = 1'b0;
    endtask

    // Pop n bytes expecting base, base+1, ...; last_val overrides the final one.
    task automatic drain_expect(input logic [7:0] base, input int n,
                                input logic use_last, input logic [7:0] last_val,
                                input string tag);
        logic [7:0] exp;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp = (use_last && i == n - 1) ? last_val : base + 8'(i);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== exp) begin
                errors++;
                $display("FAIL %s_byte%0d: valid=%b data=%h, need 1/%h",
                         tag, i, bus.o_valid, bus.o_data, exp);
            end
            tick();
        end
        bus.i_ready = 1'b0;
        checks++;
        if (bus.o_empty !== 1'b1 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty: empty=%b valid=%b, need 1/0", tag, bus.o_empty, bus.o_valid);
        end
    endtask

    task automatic test_fill_drain();
        fill(8'h00, 16);
        checks++;
        if (bus.o_full !== 1'b1 || bus.o_level !== 5'd16) begin
            errors++;
            $display("FAIL fill_full: full=%b level=%0d, need 1/16", bus.o_full, bus.o_level);
        end
        drain_expect(8'h00, 16, 1'b0, 8'h00, "fill");
        checks++;
        if (bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_ovf: ovf=%b, need 0", bus.o_overflow);
        end
    endtask

    task automatic test_overflow();
        fill(8'h00, 16);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hEE;
        tick();
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_overflow !== 1'b1 || bus.o_level !== 5'd16 || bus.o_data !== 8'h00) begin
            errors++;
            $display("FAIL ovf_drop: ovf=%b level=%0d data=%h, need 1/16/00",
                     bus.o_overflow, bus.o_level, bus.o_data);
        end
`ifdef FS_RX_FIFO_DROP_CNT_EN
        checks++;
        if (bus.o_drop_count !== 16'd1) begin
            errors++;
            $display("FAIL ovf_count: count=%0d, need 1", bus.o_drop_count);
        end
`endif
        drain_expect(8'h00, 16, 1'b0, 8'h00, "ovf");
        checks++;
        if (bus.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b, need 1", bus.o_overflow);
        end
        bus.i_clr_overflow = 1'b1;
        tick();
        bus.i_clr_overflow = 1'b0;
        checks++;
        if (bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, need 0", bus.o_overflow);
        end
`ifdef FS_RX_FIFO_DROP_CNT_EN
        checks++;
        if (bus.o_drop_count !== 16'd0) begin
            errors++;
            $display("FAIL ovf_count_clr: count=%0d, need 0", bus.o_drop_count);
        end
`endif
    endtask

    task automatic test_full_pushpop();
        fill(8'h00, 16);
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h55;
        tick();
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        checks++;
        if (bus.o_level !== 5'd16 || bus.o_data !== 8'h01 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_full: level=%0d data=%h ovf=%b, need 16/01/0",
                     bus.o_level, bus.o_data, bus.o_overflow);
        end
        drain_expect(8'h01, 16, 1'b1, 8'h55, "pushpop");
    endtask

    task automatic test_back_to_back();
        int bad_data;
        int bad_level;
        bad_data  = 0;
        bad_level = 0;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = 8'(k * 7 + 3);
            tick();
            if (bus.o_valid !== 1'b1 || bus.o_data !== 8'(k * 7 + 3)) bad_data++;
            if (bus.o_level > 5'd1) bad_level++;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL stream_data: %0d wrong bytes, need 0", bad_data);
        end
        checks++;
        if (bad_level != 0 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_level: %0d cycles level>1 ovf=%b, need 0/0",
                     bad_level, bus.o_overflow);
        end
        tick();
        bus.i_ready = 1'b0;
        checks++;
        if (bus.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL stream_end: empty=%b, need 1", bus.o_empty);
        end
    endtask

    task automatic test_reset_mid();
        fill(8'h10, 10);
        bus.i_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.i_ready = 1'b1;
        checks++;
        if (bus.o_level !== 5'd7 || bus.o_data !== 8'h13) begin
            errors++;
            $display("FAIL midrst_pre: level=%0d data=%h, need 7/13", bus.o_level, bus.o_data);
        end
        #4;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_level !== 5'd0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b level=%0d, need 0/0", bus.o_valid, bus.o_level);
        end
        tick();
        rst_n = 1'b1;
        bus.i_ready = 1'b0;
        tick();
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h3C;
        tick();
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h3C || bus.o_level !== 5'd1) begin
            errors++;
            $display("FAIL midrst_first: valid=%b data=%h level=%0d, need 1/3c/1",
                     bus.o_valid, bus.o_data, bus.o_level);
        end
        drain_expect(8'h3C, 1, 1'b0, 8'h00, "midrst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        do_reset();
        test_full_pushpop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
